// File: rtl/flow_fifo_channel.sv
// rtl/flow_fifo_channel.sv - per-flow circular-buffer FIFO with occupancy and overflow-drop pulse
module flow_fifo_channel #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_en,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_enable,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [LOG_DEPTH-1:0]  pop_dw,
  output logic                  error
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH-1:0] PTR_ONE = LOG_DEPTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [LOG_DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH-1:0]  pop_dw_q, pop_dw_d;
  logic                  pop_valid_q, pop_valid_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                  error_q, error_d;

  logic empty, full, pop_acc, push_acc;

  // Acceptance decisions and next-state; a pop frees a slot so a push into a full FIFO still lands
  always_comb begin
    empty       = (wr_ptr_q == rd_ptr_q);
    full        = ((wr_ptr_q + PTR_ONE) == rd_ptr_q);
    pop_acc     = pop_enable && !empty;
    push_acc    = push_en && (!full || pop_acc);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pop_dw_d    = pop_dw_q;
    pop_valid_d = pop_acc;
    pop_data_d  = pop_data_q;
    error_d     = push_en && !push_acc;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      pop_data_d = mem[rd_ptr_q];
    end
    if (push_acc && !pop_acc) begin
      pop_dw_d = pop_dw_q + PTR_ONE;
    end else if (pop_acc && !push_acc) begin
      pop_dw_d = pop_dw_q - PTR_ONE;
    end
  end

  // Storage write; contents are left as-is on reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (!reset && push_acc) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointer, occupancy and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_dw_q    <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_dw_q    <= pop_dw_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
      error_q     <= error_d;
    end
  end

  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;
  assign pop_dw    = pop_dw_q;
  assign error     = error_q;

endmodule

// File: tb/tb_flow_fifo_channel.sv
// tb/tb_flow_fifo_channel.sv - scoreboard bench for flow_fifo_channel against a queue model
module tb_flow_fifo_channel;

  localparam int DW  = 32;
  localparam int LD  = 3;
  localparam int CAP = (1 << LD) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          push_en;
  logic [DW-1:0] push_data;
  logic          pop_enable;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic [LD-1:0] pop_dw;
  logic          error;

  flow_fifo_channel #(.DATA_WIDTH(DW), .LOG_DEPTH(LD)) dut (
    .clk        (clk),
    .reset      (reset),
    .push_en    (push_en),
    .push_data  (push_data),
    .pop_enable (pop_enable),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_dw     (pop_dw),
    .error      (error)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_data_q[$];

  bit  chk_en   = 1'b0;
  bit  done     = 1'b0;
  bit  exp_pv   = 1'b0;
  bit  exp_err  = 1'b0;
  bit  exp_rst  = 1'b0;
  int  exp_dw   = 0;
  int  checks   = 0;
  int  failures = 0;

  // Drive one cycle: model decides acceptance from its state before the edge
  task automatic step(input bit rst, input bit pe, input logic [DW-1:0] pd, input bit pp);
    bit pop_ok, push_ok;
    reset      = rst;
    push_en    = pe;
    push_data  = pd;
    pop_enable = pp;
    pop_ok  = 1'b0;
    push_ok = 1'b0;
    if (rst) begin
      model.delete();
    end else begin
      pop_ok  = pp && (model.size() > 0);
      push_ok = pe && ((model.size() < CAP) || pop_ok);
      if (pop_ok) exp_data_q.push_back(model.pop_front());
      if (push_ok) model.push_back(pd);
    end
    @(posedge clk);
    #1;
    exp_rst = rst;
    exp_pv  = pop_ok;
    exp_err = !rst && pe && !push_ok;
    exp_dw  = model.size();
    @(negedge clk);
  endtask

  // Monitor: checks registered outputs mid-cycle, pops scoreboard on each pop_valid
  logic [DW-1:0] last_data = '0;
  always @(negedge clk) begin
    if (chk_en) begin
      logic [DW-1:0] want;
      if (exp_rst) last_data = '0;
      checks++;
      if (pop_valid !== exp_pv) begin
        failures++;
        $display("FAIL pop_valid t=%0t got=%0b want=%0b", $time, pop_valid, exp_pv);
      end
      checks++;
      if (int'(pop_dw) != exp_dw || $isunknown(pop_dw)) begin
        failures++;
        $display("FAIL pop_dw t=%0t got=%0d want=%0d", $time, pop_dw, exp_dw);
      end
      checks++;
      if (error !== exp_err) begin
        failures++;
        $display("FAIL error t=%0t got=%0b want=%0b", $time, error, exp_err);
      end
      if (pop_valid === 1'b1) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pop t=%0t got=%h want=none", $time, pop_data);
        end else begin
          want = exp_data_q.pop_front();
          last_data = want;
          if (pop_data !== want) begin
            failures++;
            $display("FAIL pop_data t=%0t got=%h want=%h", $time, pop_data, want);
          end
        end
      end else begin
        checks++;
        if (pop_data !== last_data) begin
          failures++;
          $display("FAIL pop_data_hold t=%0t got=%h want=%h", $time, pop_data, last_data);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_data_q.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain got=%0d want=0", exp_data_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pe_pct, pp_pct;
    reset = 1'b1; push_en = 1'b0; push_data = '0; pop_enable = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 0);
    chk_en = 1'b1;
    step(1, 0, 0, 0);
    // empty pop ignored
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    // basic order
    step(0, 1, 32'hA, 0);
    step(0, 1, 32'hB, 0);
    step(0, 1, 32'hC, 0);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // overflow: 8 pushes, drain
    for (int i = 0; i < 8; i++) step(0, 1, 32'h100 + i, 0);
    step(0, 0, 0, 0);
    // full: simultaneous push/pop
    step(0, 1, 32'h55, 1);
    repeat (8) step(0, 0, 0, 1);
    // empty: simultaneous push/pop, no fall-through
    step(0, 1, 32'h66, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // wrap with steady occupancy 3
    for (int i = 0; i < 3; i++) step(0, 1, 32'h200 + i, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 32'h300 + i, 1);
    repeat (4) step(0, 0, 0, 1);
    // reset mid-stream
    for (int i = 0; i < 5; i++) step(0, 1, 32'h400 + i, 0);
    step(1, 1, 32'hDEAD, 1);
    step(0, 1, 32'h77, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // randomized phases with varying push/pop bias
    for (int ph = 0; ph < 12; ph++) begin
      pe_pct = $urandom_range(10, 95);
      pp_pct = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 99) < pe_pct),
             $urandom,
             ($urandom_range(0, 99) < pp_pct));
      end
    end
    repeat (CAP + 1) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    done = 1'b1;
    @(negedge clk);
    #1;
  end

endmodule
